// File: rtl/alu_pkg.sv
// Shared ALU opcode encodings and types for the execute stage.
// No logic: constants and typedefs only.
// No flow control.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    typedef logic [1:0] alu_op_t;

    localparam alu_op_t ALU_NOR = 2'b00;
    localparam alu_op_t ALU_SLT = 2'b01;
    localparam alu_op_t ALU_ADD = 2'b10;
    localparam alu_op_t ALU_SUB = 2'b11;

    typedef struct packed {
        logic carry_out;
        logic zero;
        logic overflow;
        logic negative;
    } alu_flags_t;

endpackage

// File: rtl/alu_adder32.sv
// Combinational WIDTH-bit adder, carry-lookahead inside 4-bit groups, groups chained.
// Latency: 0 cycles (pure combinational).
// No flow control.
module alu_adder32 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    localparam int GROUPS = WIDTH / 4;

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // Each group resolves its internal carries from its own carry-in in two gate levels.
    always_comb begin
        c = '0;
        c[0] = cin;
        for (int grp = 0; grp < GROUPS; grp++) begin
            c[4*grp+1] = g[4*grp] | (p[4*grp] & c[4*grp]);
            c[4*grp+2] = g[4*grp+1] | (p[4*grp+1] & g[4*grp])
                       | (p[4*grp+1] & p[4*grp] & c[4*grp]);
            c[4*grp+3] = g[4*grp+2] | (p[4*grp+2] & g[4*grp+1])
                       | (p[4*grp+2] & p[4*grp+1] & g[4*grp])
                       | (p[4*grp+2] & p[4*grp+1] & p[4*grp] & c[4*grp]);
            c[4*grp+4] = g[4*grp+3] | (p[4*grp+3] & g[4*grp+2])
                       | (p[4*grp+3] & p[4*grp+2] & g[4*grp+1])
                       | (p[4*grp+3] & p[4*grp+2] & p[4*grp+1] & g[4*grp])
                       | (p[4*grp+3] & p[4*grp+2] & p[4*grp+1] & p[4*grp] & c[4*grp]);
        end
    end

    assign sum   = p ^ c[WIDTH-1:0];
    assign cout  = c[WIDTH];
    assign c_msb = c[WIDTH-1];

endmodule

// File: rtl/alu_reg32.sv
// Execute-stage ALU (NOR/SLT/ADD/SUB) with carry, zero, overflow and negative flags.
// Latency: 1 cycle, all outputs registered; accepts a new operation every cycle.
// No backpressure; synchronous reset clears the output bank.
module alu_reg32
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] bus_a,
    input  logic [WIDTH-1:0] bus_b,
    input  logic [1:0]       alu_control,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero,
    output logic             overflow,
    output logic             negative
);

    alu_op_t          op;
    logic [WIDTH-1:0] b_eff;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             c_msb;
    logic             add_ovf;

    logic [WIDTH-1:0] res_nxt;
    alu_flags_t       flags_nxt;

    assign op = alu_op_t'(alu_control);

    // SUB and SLT share the adder as A + ~B + 1; only ADD passes B straight through.
    assign cin   = (op != ALU_ADD);
    assign b_eff = cin ? ~bus_b : bus_b;

    alu_adder32 #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a     (bus_a),
        .b     (b_eff),
        .cin   (cin),
        .sum   (sum),
        .cout  (cout),
        .c_msb (c_msb)
    );

    assign add_ovf = c_msb ^ cout;

    always_comb begin
        res_nxt            = '0;
        flags_nxt          = '0;
        case (op)
            ALU_NOR: res_nxt = ~(bus_a | bus_b);
            ALU_SLT: res_nxt = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
            ALU_ADD, ALU_SUB: begin
                res_nxt            = sum;
                flags_nxt.carry_out = cout;
                flags_nxt.overflow  = add_ovf;
            end
            default: res_nxt = '0;
        endcase
        flags_nxt.zero     = (res_nxt == '0);
        flags_nxt.negative = res_nxt[WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result    <= '0;
            carry_out <= 1'b0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            negative  <= 1'b0;
        end else begin
            result    <= res_nxt;
            carry_out <= flags_nxt.carry_out;
            zero      <= flags_nxt.zero;
            overflow  <= flags_nxt.overflow;
            negative  <= flags_nxt.negative;
        end
    end

endmodule

// File: tb/tb_alu_reg32.sv
// Randomized and directed bench for alu_reg32 against a signed/unsigned arithmetic model.
module tb_alu_reg32;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] bus_a;
    logic [31:0] bus_b;
    logic [1:0]  alu_control;
    logic [31:0] result;
    logic        carry_out;
    logic        zero;
    logic        overflow;
    logic        negative;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] r;
        logic        c;
        logic        z;
        logic        v;
        logic        n;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
    } vec_t;

    always #5 clk = ~clk;

    alu_reg32 dut (
        .clk         (clk),
        .rst         (rst),
        .bus_a       (bus_a),
        .bus_b       (bus_b),
        .alu_control (alu_control),
        .result      (result),
        .carry_out   (carry_out),
        .zero        (zero),
        .overflow    (overflow),
        .negative    (negative)
    );

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        exp_t        e;
        longint      sa;
        longint      sb;
        longint      ex;
        logic [63:0] wide;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e  = '0;
        case (op)
            2'b10: begin
                wide = {32'd0, a} + {32'd0, b};
                ex   = sa + sb;
                e.r  = wide[31:0];
                e.c  = wide[32];
                e.v  = (ex > 64'sd2147483647) || (ex < -64'sd2147483648);
            end
            2'b11: begin
                wide = {32'd0, a} + {32'd0, ~b} + 64'd1;
                ex   = sa - sb;
                e.r  = wide[31:0];
                e.c  = wide[32];
                e.v  = (ex > 64'sd2147483647) || (ex < -64'sd2147483648);
            end
            2'b00: e.r = ~(a | b);
            default: e.r = (sa < sb) ? 32'd1 : 32'd0;
        endcase
        e.z = (e.r == 32'd0);
        e.n = e.r[31];
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag, input exp_t e);
        check({tag, ".result"},    result,           e.r);
        check({tag, ".carry_out"}, {31'd0, carry_out}, {31'd0, e.c});
        check({tag, ".zero"},      {31'd0, zero},      {31'd0, e.z});
        check({tag, ".overflow"},  {31'd0, overflow},  {31'd0, e.v});
        check({tag, ".negative"},  {31'd0, negative},  {31'd0, e.n});
    endtask

    // Present one operation, let one edge pass, then compare the registered outputs.
    task automatic step(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        bus_a       = a;
        bus_b       = b;
        alu_control = op;
        @(posedge clk);
        #1;
        if (rst) check_all(tag, exp_t'(0));
        else     check_all(tag, model(a, b, op));
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] corners [6];
        corners[0] = 32'h0000_0000;
        corners[1] = 32'hFFFF_FFFF;
        corners[2] = 32'h8000_0000;
        corners[3] = 32'h7FFF_FFFF;
        corners[4] = 32'h0000_0001;
        corners[5] = 32'hFFFF_FFFE;
        if ($urandom_range(3) == 0) return corners[$urandom_range(5)];
        return $urandom;
    endfunction

    vec_t dir [14];

    initial begin
        dir[0]  = '{32'h0000_0DEF, 32'h0000_0ABC, 2'b10};
        dir[1]  = '{32'h7FFF_FFFF, 32'h0000_0001, 2'b10};
        dir[2]  = '{32'h0000_1234, 32'hFC05_4AAA, 2'b10};
        dir[3]  = '{32'h0000_0DEF, 32'h0000_0ABC, 2'b11};
        dir[4]  = '{32'h8000_0000, 32'h0000_0001, 2'b11};
        dir[5]  = '{32'h0000_1234, 32'h0000_1234, 2'b11};
        dir[6]  = '{32'h0000_0001, 32'hFFFF_FFFE, 2'b00};
        dir[7]  = '{32'h0000_1234, 32'h0000_0105, 2'b00};
        dir[8]  = '{32'h0000_000A, 32'hFFFF_FFFE, 2'b01};
        dir[9]  = '{32'h0000_000A, 32'h0000_0105, 2'b01};
        dir[10] = '{32'h8000_0000, 32'h8000_0000, 2'b01};
        dir[11] = '{32'h8000_0000, 32'h0000_0001, 2'b01};
        dir[12] = '{32'hFFFF_FFFF, 32'h0000_0001, 2'b10};
        dir[13] = '{32'h0000_0001, 32'h8000_0000, 2'b01};

        rst         = 1'b1;
        bus_a       = 32'hDEAD_BEEF;
        bus_b       = 32'h1234_5678;
        alu_control = 2'b10;

        // Reset held two cycles with live operands must leave everything cleared.
        step("rst0", 32'hFFFF_FFFF, 32'h0000_0001, 2'b10);
        step("rst1", 32'h7FFF_FFFF, 32'h0000_0001, 2'b11);
        check("rst_const.result", result, 32'd0);

        rst = 1'b0;
        step("post_rst", 32'h0000_0DEF, 32'h0000_0ABC, 2'b10);

        for (int i = 0; i < 14; i++)
            step($sformatf("dir%0d", i), dir[i].a, dir[i].b, dir[i].op);

        // Independent spot values for the overflow and SLT sign-boundary cases.
        step("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 2'b10);
        check("add_ovf.abs", result, 32'h8000_0000);
        step("slt_minneg", 32'h8000_0000, 32'h0000_0001, 2'b01);
        check("slt_minneg.abs", result, 32'h0000_0001);

        // Back-to-back rotation through every op, one per cycle.
        for (int i = 0; i < 16; i++)
            step($sformatf("b2b%0d", i), pick_operand(), pick_operand(), 2'(i % 4 == 0 ? 2 : i % 4 == 1 ? 3 : i % 4 == 2 ? 0 : 1));

        // Reset mid-stream drops the in-flight op; next op lands one cycle after release.
        rst = 1'b1;
        step("mid_rst", 32'h7FFF_FFFF, 32'h0000_0001, 2'b10);
        rst = 1'b0;
        step("mid_post", 32'h8000_0000, 32'h0000_0001, 2'b11);

        for (int i = 0; i < 300; i++)
            step($sformatf("rnd%0d", i), pick_operand(), pick_operand(), 2'($urandom_range(3)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
